sec32_encoder: RTL and testbench
================================

SEC32_ENCODER -- requirements
Module: sec32_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the encoder can accept a word.
REQ-005 SHALL have port in_data, input, 32 bits: data word d[31:0].
REQ-006 SHALL have port out_valid, output, 1 bit: a codeword is presented.
REQ-007 SHALL have port out_ready, input, 1 bit: downstream accepts the codeword.
REQ-008 SHALL have port out_data, output, 32 bits: data unchanged from the input.
REQ-009 SHALL have port out_check, output, 8 bits: check bits c[7:0].
REQ-010 SHALL have port out_parity, output, 1 bit: overall parity; present only with SEC32_ENC_SECDED_EN.
REQ-011 SHALL have port word_count, output, 16 bits: number of codewords delivered, wrapping.

Function
REQ-012 SHALL compute c[k] as the XOR-reduction of (d AND MASK[k]), using even parity.
REQ-013 SHALL use these masks, so that the matching corrector sees a zero syndrome:
- MASK0 = 0x00FF1111
- MASK1 = 0xFF002222
- MASK2 = 0x0F0F4444
- MASK3 = 0xF0F08888
- MASK4 = 0x111100FF
- MASK5 = 0x2222FF00
- MASK6 = 0x44440F0F
- MASK7 = 0x8888F0F0
REQ-014 SHALL complete a handshake on an interface in any cycle where both valid and ready are high at the rising edge.
REQ-015 SHALL have a latency of 1 cycle: a word accepted at edge N is presented on out_* after edge N. Throughput SHALL be one word per cycle while out_ready is high.
REQ-016 SHALL hold the output stage plus a one-entry skid register, giving 2 entries in total.
REQ-017 SHALL drive in_ready as a registered signal equal to !skid_full; it never combinationally depends on out_ready.
REQ-018 SHALL load an accepted word into the skid register when out_valid=1 and out_ready=0. in_ready SHALL drop after that edge.
REQ-019 SHALL move the skid word to the output stage when the output handshakes with the skid full. in_ready SHALL return high after that edge.
REQ-020 SHALL hold out_data, out_check, out_parity and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL deliver words in acceptance order; no word is dropped or duplicated.
REQ-022 SHALL handle an output handshake and an input acceptance in the same cycle with the output stage refilled from skid (if full) or from the input, and no bubble.
REQ-023 SHALL increment word_count by 1 on each output handshake; 0xFFFF SHALL wrap to 0x0000.

Reset
REQ-024 SHALL, while rst=1 at an edge, set out_valid=0, skid empty, word_count=0, out_data=0, out_check=0, out_parity=0.
REQ-025 SHALL force in_ready=0 while rst is high. in_ready SHALL be 1 from the first edge with rst=0.
REQ-026 SHALL discard any word in flight, in the output stage or skid, when reset occurs mid-operation; no partial delivery.

Configuration
REQ-027 SHALL, when SEC32_ENC_SECDED_EN is defined, provide out_parity = XOR of all 32 data bits and 8 check bits (SECDED, 41-bit codeword). The parity SHALL be registered alongside out_check.
REQ-028 SHALL, when SEC32_ENC_SECDED_EN is undefined, omit the out_parity port and its logic (SEC only, 40-bit codeword).

Structure
REQ-029 SHALL place the following in shared package sec32_pkg:
- the MASK[0..7] constants
- the CHECK_W=8 and DATA_W=32 constants
- a codeword typedef (data, check, optional parity)
REQ-030 SHALL use one combinational sub-module, sec32_checkgen (data in, check/parity out), instantiated once on the input path.

Verification
REQ-031 SHALL cover: in_data=0x00000000 -> out_check=0x00, out_parity=0, 1 cycle later.
REQ-032 SHALL cover: in_data=0x00000001 -> out_check=0x51; in_data=0x80000000 -> out_check=0x8A; out_parity=0 in both cases.
REQ-033 SHALL cover: in_data=0xFFFFFFFF -> out_check=0x00, out_parity=0.
REQ-034 SHALL cover: stream of 4 words with out_ready held 0 -> 2 words buffered, in_ready=0 from the cycle after the 2nd accept. Raising out_ready SHALL deliver the words in order with word_count=2.
REQ-035 SHALL cover: preload word_count=0xFFFF via 65535 deliveries, then one more -> word_count=0x0000.
REQ-036 SHALL cover: assert rst with both entries full -> out_valid=0, word_count=0 after the edge; no stale word appears afterwards.

Source files
------------

// File: rtl/sec32_pkg.sv
// Shared constants, codeword type and XOR helper for the SEC32 encoder.
// Optional SECDED overall parity is enabled by defining SEC32_ENC_SECDED_EN.
package sec32_pkg;

  localparam int DATA_W  = 32;
  localparam int CHECK_W = 8;

  localparam logic [DATA_W-1:0] MASK0 = 32'h00FF_1111;
  localparam logic [DATA_W-1:0] MASK1 = 32'hFF00_2222;
  localparam logic [DATA_W-1:0] MASK2 = 32'h0F0F_4444;
  localparam logic [DATA_W-1:0] MASK3 = 32'hF0F0_8888;
  localparam logic [DATA_W-1:0] MASK4 = 32'h1111_00FF;
  localparam logic [DATA_W-1:0] MASK5 = 32'h2222_FF00;
  localparam logic [DATA_W-1:0] MASK6 = 32'h4444_0F0F;
  localparam logic [DATA_W-1:0] MASK7 = 32'h8888_F0F0;

  // Index k of MASKS selects the mask for check bit c[k].
  localparam logic [CHECK_W-1:0][DATA_W-1:0] MASKS =
    {MASK7, MASK6, MASK5, MASK4, MASK3, MASK2, MASK1, MASK0};

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [CHECK_W-1:0] check;
`ifdef SEC32_ENC_SECDED_EN
    logic               parity;
`endif
  } codeword_t;

  function automatic logic masked_parity(input logic [DATA_W-1:0] d,
                                         input logic [DATA_W-1:0] m);
    return ^(d & m);
  endfunction

endpackage

// File: rtl/sec32_encoder_if.sv
// Valid/ready stream bundle for the SEC32 encoder (input word, output codeword).
// out_parity exists only when SEC32_ENC_SECDED_EN is defined.
interface sec32_encoder_if;
  import sec32_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [CHECK_W-1:0]  out_check;
`ifdef SEC32_ENC_SECDED_EN
  logic                out_parity;
`endif

  modport master (
    output in_valid, in_data, out_ready,
`ifdef SEC32_ENC_SECDED_EN
    input  out_parity,
`endif
    input  in_ready, out_valid, out_data, out_check
  );

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef SEC32_ENC_SECDED_EN
    output out_parity,
`endif
    output in_ready, out_valid, out_data, out_check
  );

endinterface

// File: rtl/sec32_checkgen.sv
// Combinational check-bit generator; with SEC32_ENC_SECDED_EN it also
// produces the overall parity of the 41-bit codeword.
module sec32_checkgen
  import sec32_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
`ifdef SEC32_ENC_SECDED_EN
  output logic               parity,
`endif
  output logic [CHECK_W-1:0] check
);

  logic [CHECK_W-1:0] check_s;

  // Each check bit is the even parity of the data bits its mask selects.
  always_comb begin
    check_s = '0;
    for (int k = 0; k < CHECK_W; k++) begin
      check_s[k] = masked_parity(data, MASKS[k]);
    end
  end

  assign check = check_s;

`ifdef SEC32_ENC_SECDED_EN
  assign parity = ^{data, check_s};
`endif

endmodule

// File: rtl/sec32_encoder.sv
// SEC32 encoder: one-cycle output stage plus a one-entry skid buffer.
// Optional overall parity output is enabled by defining SEC32_ENC_SECDED_EN.
module sec32_encoder
  import sec32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  sec32_encoder_if.slave  bus,
  output logic [15:0]     word_count
);

  logic [CHECK_W-1:0] chk_s;
  codeword_t          in_cw_s;
  logic               in_fire_s;
  logic               out_fire_s;
  logic               out_free_s;

  codeword_t          out_cw_r,    out_cw_s;
  logic               out_valid_r, out_valid_s;
  codeword_t          skid_cw_r,   skid_cw_s;
  logic               skid_full_r, skid_full_s;
  logic               in_ready_r;
  logic [15:0]        word_count_r;

`ifdef SEC32_ENC_SECDED_EN
  logic par_s;

  sec32_checkgen u_checkgen (
    .data   (bus.in_data),
    .parity (par_s),
    .check  (chk_s)
  );
`else
  sec32_checkgen u_checkgen (
    .data   (bus.in_data),
    .check  (chk_s)
  );
`endif

  // Assemble the codeword for the word currently offered upstream.
  always_comb begin
    in_cw_s       = '0;
    in_cw_s.data  = bus.in_data;
    in_cw_s.check = chk_s;
`ifdef SEC32_ENC_SECDED_EN
    in_cw_s.parity = par_s;
`endif
  end

  assign in_fire_s  = bus.in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & bus.out_ready;
  assign out_free_s = ~out_valid_r | bus.out_ready;

  // Next state: the skid (if full) has priority over new input for the output stage.
  always_comb begin
    out_valid_s = out_valid_r;
    out_cw_s    = out_cw_r;
    skid_full_s = skid_full_r;
    skid_cw_s   = skid_cw_r;
    if (out_free_s) begin
      if (skid_full_r) begin
        out_valid_s = 1'b1;
        out_cw_s    = skid_cw_r;
        skid_full_s = 1'b0;
      end else if (in_fire_s) begin
        out_valid_s = 1'b1;
        out_cw_s    = in_cw_s;
      end else begin
        out_valid_s = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_full_s = 1'b1;
      skid_cw_s   = in_cw_s;
    end else begin
      skid_full_s = skid_full_r;
    end
  end

  // State registers; in_ready tracks the next skid state so it never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_cw_r     <= '0;
      skid_full_r  <= 1'b0;
      skid_cw_r    <= '0;
      in_ready_r   <= 1'b0;
      word_count_r <= 16'd0;
    end else begin
      out_valid_r  <= out_valid_s;
      out_cw_r     <= out_cw_s;
      skid_full_r  <= skid_full_s;
      skid_cw_r    <= skid_cw_s;
      in_ready_r   <= ~skid_full_s;
      word_count_r <= word_count_r + (out_fire_s ? 16'd1 : 16'd0);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_cw_r.data;
  assign bus.out_check = out_cw_r.check;
`ifdef SEC32_ENC_SECDED_EN
  assign bus.out_parity = out_cw_r.parity;
`endif
  assign word_count = word_count_r;

endmodule

// File: tb/tb_sec32_encoder.sv
// Directed self-checking bench for sec32_encoder (check bits, skid, reset, counter wrap).
// Parity checks are included when SEC32_ENC_SECDED_EN is defined.
module tb_sec32_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] word_count;
  int          total;
  int          bad;

  sec32_encoder_if bus ();

  sec32_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed vectors: data and the expected check byte.
  logic [31:0] vec_d [6];
  logic [7:0]  vec_c [6];

  initial begin
    vec_d[0] = 32'h0000_0000; vec_c[0] = 8'h00;
    vec_d[1] = 32'h0000_0001; vec_c[1] = 8'h51;
    vec_d[2] = 32'h8000_0000; vec_c[2] = 8'h8A;
    vec_d[3] = 32'hFFFF_FFFF; vec_c[3] = 8'h00;
    vec_d[4] = 32'h0000_0100; vec_c[4] = 8'h61;
    vec_d[5] = 32'h0001_0000; vec_c[5] = 8'h15;
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid",  32'(bus.out_valid), 32'd0);
    check("rst_in_ready",   32'(bus.in_ready),  32'd0);
    check("rst_count",      32'(word_count),    32'd0);
    check("rst_out_data",   bus.out_data,       32'd0);
    check("rst_out_check",  32'(bus.out_check), 32'd0);
`ifdef SEC32_ENC_SECDED_EN
    check("rst_out_parity", 32'(bus.out_parity), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Back-to-back vectors, one per cycle, each visible one edge after acceptance.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec_d[i];
      tick();
      check("vec_valid", 32'(bus.out_valid), 32'd1);
      check("vec_data",  bus.out_data,       vec_d[i]);
      check("vec_check", 32'(bus.out_check), 32'(vec_c[i]));
`ifdef SEC32_ENC_SECDED_EN
      check("vec_parity", 32'(bus.out_parity), 32'd0);
`endif
    end
    bus.in_valid = 1'b0;
    tick();
    check("vec_drain_valid", 32'(bus.out_valid), 32'd0);
    check("vec_count",       32'(word_count),    32'd6);

    // Stall: four words offered with out_ready low; only two fit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = vec_d[1];
    tick();
    check("stall_ready1", 32'(bus.in_ready),  32'd1);
    check("stall_valid1", 32'(bus.out_valid), 32'd1);
    bus.in_data = vec_d[2];
    tick();
    check("stall_ready2", 32'(bus.in_ready), 32'd0);
    bus.in_data = vec_d[4];
    tick();
    check("stall_ready3", 32'(bus.in_ready), 32'd0);
    check("stall_hold_d", bus.out_data,       vec_d[1]);
    check("stall_hold_c", 32'(bus.out_check), 32'(vec_c[1]));
    bus.in_data = vec_d[5];
    tick();
    check("stall_ready4", 32'(bus.in_ready), 32'd0);
    check("stall_hold2",  bus.out_data,      vec_d[1]);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("drain1_data",  bus.out_data,       vec_d[2]);
    check("drain1_check", 32'(bus.out_check), 32'(vec_c[2]));
    check("drain1_ready", 32'(bus.in_ready),  32'd1);
    check("drain1_count", 32'(word_count),    32'd1);
    tick();
    check("drain2_valid", 32'(bus.out_valid), 32'd0);
    check("drain2_count", 32'(word_count),    32'd2);

    // Reset with both entries full must discard everything.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = vec_d[4];
    tick();
    bus.in_data = vec_d[5];
    tick();
    check("full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_count", 32'(word_count),    32'd0);
    check("midrst_ready", 32'(bus.in_ready),  32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end
    check("post_rst_count", 32'(word_count), 32'd0);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Counter wrap: continuous stream, one delivery per cycle.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0001;
    n = 0;
    while (word_count != 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    check("wrap_reach_ffff", 32'(word_count), 32'h0000_FFFF);
    check("wrap_ticks",      32'(n),          32'd65536);
    bus.in_valid = 1'b0;
    tick();
    check("wrap_zero",  32'(word_count),    32'd0);
    check("wrap_empty", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
